// File: rtl/register_file_multi_port_write_32b_1r_64b.sv
// rtl/register_file_multi_port_write_32b_1r_64b.sv - N 32b write ports, one 64b read port flip-flop register file
// Writes are staged for one cycle, then committed; same-half collisions go to the lowest port index.
module register_file_multi_port_write_32b_1r_64b #(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 64,
  parameter int WDATA_WIDTH = 32,
  parameter int WADDR_WIDTH = RADDR_WIDTH + $clog2(RDATA_WIDTH / WDATA_WIDTH),
  parameter int N_WRITE     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ReadEnable,
  input  logic [RADDR_WIDTH-1:0]                ReadAddr,
  output logic [RDATA_WIDTH-1:0]                ReadData,
  input  logic [N_WRITE-1:0]                    WriteEnable,
  input  logic [N_WRITE-1:0][WADDR_WIDTH-1:0]   WriteAddr,
  input  logic [N_WRITE-1:0][WDATA_WIDTH-1:0]   WriteData,
  output logic [N_WRITE-1:0]                    WriteConflict
);

  localparam int HALVES     = RDATA_WIDTH / WDATA_WIDTH;
  localparam int HALF_BITS  = WADDR_WIDTH - RADDR_WIDTH;
  localparam int NUM_HALVES = 2 ** WADDR_WIDTH;

  // Storage is kept as half-words so a write port addresses one entry directly.
  logic [WDATA_WIDTH-1:0]                  mem [NUM_HALVES];
  logic [RADDR_WIDTH-1:0]                  raddr_reg;
  logic [N_WRITE-1:0]                      stage_en;
  logic [N_WRITE-1:0][WADDR_WIDTH-1:0]     stage_addr;
  logic [N_WRITE-1:0][WDATA_WIDTH-1:0]     stage_data;
  logic [N_WRITE-1:0]                      win;

  // A staged port wins unless a lower-index staged port targets the same half.
  always_comb begin
    win = stage_en;
    for (int p = 0; p < N_WRITE; p++) begin
      for (int q = 0; q < N_WRITE; q++) begin
        if (q < p && stage_en[q] && stage_en[p] && stage_addr[q] == stage_addr[p]) begin
          win[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_HALVES; i++) begin
        mem[i] <= '0;
      end
      raddr_reg     <= '0;
      stage_en      <= '0;
      stage_addr    <= '0;
      stage_data    <= '0;
      WriteConflict <= '0;
    end else begin
      if (ReadEnable) begin
        raddr_reg <= ReadAddr;
      end
      stage_en   <= WriteEnable;
      stage_addr <= WriteAddr;
      for (int p = 0; p < N_WRITE; p++) begin
        if (WriteEnable[p]) begin
          stage_data[p] <= WriteData[p];
        end
      end
      // Winners have distinct addresses, so iteration order does not matter.
      for (int p = 0; p < N_WRITE; p++) begin
        if (win[p]) begin
          mem[stage_addr[p]] <= stage_data[p];
        end
      end
      WriteConflict <= stage_en & ~win;
    end
  end

  for (genvar h = 0; h < HALVES; h++) begin : g_rd
    localparam logic [HALF_BITS-1:0] HSEL = HALF_BITS'(h);
    assign ReadData[h*WDATA_WIDTH +: WDATA_WIDTH] = mem[{raddr_reg, HSEL}];
  end

endmodule
